// File: rtl/ram_seq_82s21.sv
// Access sequencer for a 32x2 82S21-style bipolar RAM.
// Clears the array after reset, then serves single host reads/writes.
module ram_seq_82s21 #(
  parameter int WPULSE_CYC = 2,
  parameter int RD_WAIT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [4:0] req_addr,
  input  logic [1:0] req_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_rdata,
  output logic       init_done,
  output logic [4:0] ram_a,
  output logic [1:0] ram_i,
  output logic       ram_we0_n,
  output logic       ram_we1_n,
  output logic       ram_wclk_n,
  output logic       ram_strobe,
  output logic       ram_ce,
  input  logic [1:0] ram_d
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] WPULSE  = 3'd2;
  localparam logic [2:0] WHOLD   = 3'd3;
  localparam logic [2:0] RSTROBE = 3'd4;
  localparam logic [2:0] RSAMPLE = 3'd5;

  localparam logic [3:0] WP_LAST = 4'(WPULSE_CYC - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] icnt_q, icnt_d;
  logic       done_q, done_d;
  logic       wr_q, wr_d;
  logic [4:0] a_q, a_d;
  logic [1:0] i_q, i_d;
  logic       ready_q, ready_d;
  logic       rvld_q, rvld_d;
  logic [1:0] rdata_q, rdata_d;
  logic       wpin_q, wpin_d;
  logic       strb_q, strb_d;
  logic       ce_q, ce_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icnt_d  = icnt_q;
    done_d  = done_q;
    wr_d    = wr_q;
    a_d     = a_q;
    i_d     = i_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!done_q) begin
          state_d = SETUP;
          wr_d    = 1'b1;
          a_d     = icnt_q;
          i_d     = 2'b00;
        end else if (req_valid && ready_q) begin
          state_d = SETUP;
          wr_d    = req_write;
          a_d     = req_addr;
          i_d     = req_wdata;
        end
      end
      SETUP: begin
        state_d = wr_q ? WPULSE : RSTROBE;
        cnt_d   = wr_q ? WP_LAST : RD_LAST;
      end
      WPULSE: begin
        if (cnt_q == 4'd0) state_d = WHOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WHOLD: begin
        state_d = IDLE;
        // init clear walks the counter; last address flags completion
        if (!done_q) begin
          if (icnt_q == 5'd31) done_d = 1'b1;
          else                 icnt_d = icnt_q + 5'd1;
        end
      end
      RSTROBE: begin
        if (cnt_q == 4'd0) state_d = RSAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RSAMPLE: begin
        state_d = IDLE;
        rvld_d  = 1'b1;
        rdata_d = ram_d;
      end
      default: state_d = IDLE;
    endcase
  end

  // pin registers are decoded from the next state so every pin is a flop
  always_comb begin
    ce_d    = (state_d != IDLE);
    strb_d  = (state_d == RSTROBE);
    wpin_d  = (state_d != WPULSE);
    ready_d = (state_d == IDLE) && done_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      icnt_q  <= 5'd0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      a_q     <= 5'd0;
      i_q     <= 2'b00;
      ready_q <= 1'b0;
      rvld_q  <= 1'b0;
      rdata_q <= 2'b00;
      wpin_q  <= 1'b1;
      strb_q  <= 1'b0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      i_q     <= i_d;
      ready_q <= ready_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      wpin_q  <= wpin_d;
      strb_q  <= strb_d;
      ce_q    <= ce_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rvld_q;
  assign rsp_rdata  = rdata_q;
  assign init_done  = done_q;
  assign ram_a      = a_q;
  assign ram_i      = i_q;
  assign ram_we0_n  = wpin_q;
  assign ram_we1_n  = wpin_q;
  assign ram_wclk_n = wpin_q;
  assign ram_strobe = strb_q;
  assign ram_ce     = ce_q;

endmodule
